// File: rtl/sram_word_engine_if.sv
// Command bus from the memory controller plus the SRAM pad signals.
// The engine takes the slave side; the controller/pads (or a bench) take the master side.
interface sram_word_engine_if;
    logic        start;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [17:0] sram_addr;
    logic [15:0] sram_data_out;
    logic        sram_data_oe;
    logic [15:0] sram_data_in;
    logic        sram_cs_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    modport master (
        output start, cmd, addr, wdata, wstrb, sram_data_in,
        input  busy, done, rdata, sram_addr, sram_data_out, sram_data_oe,
               sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

    modport slave (
        input  start, cmd, addr, wdata, wstrb, sram_data_in,
        output busy, done, rdata, sram_addr, sram_data_out, sram_data_oe,
               sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/sram_word_engine.sv
// Executes one 32-bit read/write command as two 16-bit accesses on an async SRAM.
// Every output is a register loaded from the next-state decode, so pins change only on clk.
module sram_word_engine #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    sram_word_engine_if.slave bus
);
    localparam logic [7:0] CMD_RD = 8'h01;
    localparam logic [7:0] CMD_WR = 8'h02;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;

    state_t      state, state_d;
    logic        half, half_d;
    logic [3:0]  cnt, cnt_d;
    logic        is_wr, is_wr_d;
    logic [16:0] waddr, waddr_d;
    logic [31:0] wdat, wdat_d;
    logic [3:0]  strb, strb_d;
    logic [31:0] rdata, rdata_d;

    logic        busy, busy_d, done, done_d;
    logic [17:0] sram_addr, sram_addr_d;
    logic [15:0] dout, dout_d;
    logic        data_oe, data_oe_d;
    logic        cs_n, cs_n_d, oe_n, oe_n_d, we_n, we_n_d, ub_n, ub_n_d, lb_n, lb_n_d;
    logic [1:0]  lane_strb;
    logic        active;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[31:19], bus.addr[1:0]};

    always_comb begin
        state_d = state;
        half_d  = half;
        cnt_d   = cnt;
        is_wr_d = is_wr;
        waddr_d = waddr;
        wdat_d  = wdat;
        strb_d  = strb;
        rdata_d = rdata;
        case (state)
            IDLE: if (bus.start) begin
                is_wr_d = (bus.cmd == CMD_WR);
                waddr_d = bus.addr[18:2];
                wdat_d  = bus.wdata;
                strb_d  = bus.wstrb;
                if (bus.cmd == CMD_RD) begin
                    half_d  = 1'b0;
                    state_d = SETUP;
                end else if (bus.cmd == CMD_WR && bus.wstrb != 4'h0) begin
                    half_d  = (bus.wstrb[1:0] == 2'b00);
                    state_d = SETUP;
                end else begin
                    state_d = DONE;
                end
            end
            SETUP: begin
                cnt_d   = 4'(ACCESS_CYCLES - 1);
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_d = HOLD;
                    if (!is_wr) begin
                        if (half) rdata_d[31:16] = bus.sram_data_in;
                        else      rdata_d[15:0]  = bus.sram_data_in;
                    end
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (!half && (!is_wr || strb[3:2] != 2'b00)) begin
                    half_d  = 1'b1;
                    state_d = SETUP;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pin values for the cycle we are about to enter.
        active      = (state_d == SETUP) || (state_d == ACCESS) || (state_d == HOLD);
        lane_strb   = half_d ? strb_d[3:2] : strb_d[1:0];
        busy_d      = active;
        done_d      = (state_d == DONE);
        sram_addr_d = sram_addr;
        dout_d      = dout;
        data_oe_d   = 1'b0;
        cs_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        if (active) begin
            cs_n_d      = 1'b0;
            sram_addr_d = {waddr_d, half_d};
            if (is_wr_d) begin
                data_oe_d = 1'b1;
                dout_d    = half_d ? wdat_d[31:16] : wdat_d[15:0];
                {ub_n_d, lb_n_d} = ~lane_strb;
                we_n_d    = (state_d != ACCESS);
            end else begin
                {ub_n_d, lb_n_d} = 2'b00;
                oe_n_d    = (state_d == HOLD);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            half      <= 1'b0;
            cnt       <= 4'd0;
            is_wr     <= 1'b0;
            waddr     <= '0;
            wdat      <= '0;
            strb      <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sram_addr <= '0;
            dout      <= '0;
            data_oe   <= 1'b0;
            cs_n      <= 1'b1;
            oe_n      <= 1'b1;
            we_n      <= 1'b1;
            ub_n      <= 1'b1;
            lb_n      <= 1'b1;
        end else begin
            state     <= state_d;
            half      <= half_d;
            cnt       <= cnt_d;
            is_wr     <= is_wr_d;
            waddr     <= waddr_d;
            wdat      <= wdat_d;
            strb      <= strb_d;
            rdata     <= rdata_d;
            busy      <= busy_d;
            done      <= done_d;
            sram_addr <= sram_addr_d;
            dout      <= dout_d;
            data_oe   <= data_oe_d;
            cs_n      <= cs_n_d;
            oe_n      <= oe_n_d;
            we_n      <= we_n_d;
            ub_n      <= ub_n_d;
            lb_n      <= lb_n_d;
        end
    end

    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.rdata         = rdata;
    assign bus.sram_addr     = sram_addr;
    assign bus.sram_data_out = dout;
    assign bus.sram_data_oe  = data_oe;
    assign bus.sram_cs_n     = cs_n;
    assign bus.sram_oe_n     = oe_n;
    assign bus.sram_we_n     = we_n;
    assign bus.sram_ub_n     = ub_n;
    assign bus.sram_lb_n     = lb_n;
endmodule

// File: tb/tb_sram_word_engine.sv
// Scoreboarded bench: expected completions are queued at issue and retired on done,
// with a behavioural 16-bit SRAM attached to the pins.
module tb_sram_word_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_word_engine_if ifc ();
    sram_word_engine #(.ACCESS_CYCLES(2)) dut (.clk(clk), .reset(reset), .bus(ifc));

    typedef struct { int e0; int lat; bit is_rd; logic [31:0] rd; } exp_t;
    typedef struct { logic [17:0] a; logic ub_n; logic lb_n; } wr_t;

    exp_t sb[$];
    wr_t  wlog[$];
    logic [15:0] mem [int];
    int n_chk = 0, n_pass = 0;
    int cyc = 0, n_done = 0, d0 = 0;
    int cs_low = 0, doe_hi = 0, we_low = 0, inv_bad = 0;
    logic we_prev = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: writes land on every clk edge that sees we_n low.
    always @(posedge clk) begin
        if (!reset && !ifc.sram_cs_n && !ifc.sram_we_n) begin
            we_low++;
            if (we_prev) wlog.push_back('{ifc.sram_addr, ifc.sram_ub_n, ifc.sram_lb_n});
            begin
                logic [15:0] w;
                w = mem.exists(int'(ifc.sram_addr)) ? mem[int'(ifc.sram_addr)] : 16'h0;
                if (!ifc.sram_lb_n) w[7:0]  = ifc.sram_data_out[7:0];
                if (!ifc.sram_ub_n) w[15:8] = ifc.sram_data_out[15:8];
                mem[int'(ifc.sram_addr)] = w;
            end
        end
        we_prev = ifc.sram_we_n || ifc.sram_cs_n;
    end

    always @(negedge clk) begin
        if (!ifc.sram_cs_n && !ifc.sram_oe_n)
            ifc.sram_data_in = mem.exists(int'(ifc.sram_addr)) ? mem[int'(ifc.sram_addr)] : 16'h0;
        else
            ifc.sram_data_in = 16'hA5A5;
        if (!reset) begin
            if (ifc.sram_data_oe && !ifc.sram_oe_n) inv_bad++;
            if (ifc.busy && ifc.done) inv_bad++;
            if (!ifc.sram_cs_n) cs_low++;
            if (ifc.sram_data_oe) doe_hi++;
            if (ifc.done) begin
                n_done++;
                if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_latency", 32'(cyc - e.e0 + 1), 32'(e.lat));
                    if (e.is_rd) chk("rdata", ifc.rdata, e.rd);
                end
            end
        end
    end

    task automatic issue(input logic [7:0] c, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input bit push, input int lat,
                         input bit is_rd, input logic [31:0] rd);
        @(negedge clk);
        d0 = n_done; cs_low = 0; doe_hi = 0; we_low = 0; wlog.delete();
        ifc.start = 1'b1; ifc.cmd = c; ifc.addr = a; ifc.wdata = wd; ifc.wstrb = ws;
        @(posedge clk);
        #1;
        if (push) sb.push_back('{cyc, lat, is_rd, rd});
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && n_done == d0; i++) begin
            @(negedge clk);
            #1;
        end
        if (n_done == d0) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic run_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input int lat, input bit is_rd,
                           input logic [31:0] rd);
        issue(c, a, wd, ws, 1'b1, lat, is_rd, rd);
        wait_done();
    endtask

    initial begin
        ifc.start = 1'b0; ifc.cmd = 8'h0; ifc.addr = '0; ifc.wdata = '0; ifc.wstrb = '0;
        ifc.sram_data_in = 16'hA5A5;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cs_low = 0;
        repeat (10) @(negedge clk);
        chk("rst_ctl", {27'd0, ifc.sram_cs_n, ifc.sram_oe_n, ifc.sram_we_n, ifc.sram_ub_n, ifc.sram_lb_n}, 32'h1F);
        chk("rst_busy_done_oe", {29'd0, ifc.busy, ifc.done, ifc.sram_data_oe}, 32'd0);
        chk("rst_rdata", ifc.rdata, 32'd0);
        chk("rst_addr_dout", {ifc.sram_addr, 14'd0} | {16'd0, ifc.sram_data_out}, 32'd0);
        chk("rst_idle_cs", 32'(cs_low), 32'd0);

        // Full-word write: two halfword accesses, low half first.
        run_cmd(8'h02, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 9, 1'b0, '0);
        chk("fw_nacc", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("fw_addr0", 32'(wlog[0].a), 32'h082);
            chk("fw_addr1", 32'(wlog[1].a), 32'h083);
        end
        chk("fw_we_low", 32'(we_low), 32'd4);
        chk("fw_mem_lo", 32'(mem[32'h82]), 32'hBEEF);
        chk("fw_mem_hi", 32'(mem[32'h83]), 32'hDEAD);

        run_cmd(8'h01, 32'h0000_0104, '0, 4'h0, 9, 1'b1, 32'hDEAD_BEEF);
        chk("rd_data_oe", 32'(doe_hi), 32'd0);

        // Single byte in the high half.
        run_cmd(8'h02, 32'h0000_0104, 32'h00AA_0000, 4'h4, 5, 1'b0, '0);
        chk("bw_nacc", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) chk("bw_acc", {12'd0, wlog[0].a, wlog[0].ub_n, wlog[0].lb_n}, {12'd0, 18'h083, 1'b1, 1'b0});
        run_cmd(8'h01, 32'h0000_0104, '0, 4'h0, 9, 1'b1, 32'hDEAA_BEEF);

        // Low-half-only write ignores addr[31:19] and addr[1:0].
        run_cmd(8'h02, 32'hFFF8_0207, 32'h0000_1234, 4'h3, 5, 1'b0, '0);
        chk("lw_nacc", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) chk("lw_addr", 32'(wlog[0].a), 32'h102);
        run_cmd(8'h01, 32'h0000_0204, '0, 4'h0, 9, 1'b1, 32'h0000_1234);

        run_cmd(8'h07, 32'h0000_0104, '0, 4'hF, 1, 1'b0, '0);
        chk("noop_cs", 32'(cs_low), 32'd0);
        run_cmd(8'h02, 32'h0000_0104, 32'hFFFF_FFFF, 4'h0, 1, 1'b0, '0);
        chk("zstrb_cs", 32'(cs_low), 32'd0);

        // A start pulsed mid-read must be dropped.
        issue(8'h01, 32'h0000_0104, '0, 4'h0, 1'b1, 9, 1'b1, 32'hDEAA_BEEF);
        @(negedge clk);
        ifc.start = 1'b1; ifc.cmd = 8'h02; ifc.addr = 32'h0000_0104; ifc.wdata = '0; ifc.wstrb = 4'hF;
        @(negedge clk);
        ifc.start = 1'b0;
        wait_done();
        repeat (15) @(negedge clk);
        chk("ignored_start_ndone", 32'(n_done - d0), 32'd1);
        chk("ignored_start_mem", 32'(mem[32'h83]), 32'hDEAA);

        // Reset in the middle of a write access.
        issue(8'h02, 32'h0000_0300, 32'h1234_5678, 4'hF, 1'b0, 0, 1'b0, '0);
        for (int i = 0; i < 20 && ifc.sram_we_n; i++) @(negedge clk);
        chk("mid_we_seen", {31'd0, ifc.sram_we_n}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_pins", {26'd0, ifc.busy, ifc.sram_cs_n, ifc.sram_we_n, ifc.sram_oe_n, ifc.sram_data_oe, ifc.done},
            {26'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        reset = 1'b0;
        d0 = n_done;
        repeat (12) @(negedge clk);
        chk("mid_rst_nodone", 32'(n_done - d0), 32'd0);
        run_cmd(8'h01, 32'h0000_0104, '0, 4'h0, 9, 1'b1, 32'hDEAA_BEEF);

        chk("invariants", 32'(inv_bad), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
